cal_seq_ctrl: RTL
=================

// Module: cal_seq_ctrl
// PURPOSE
//  Sequencer for the two-operand pushbutton calculator.
//  - Collects two 2-digit BCD operands from a keypad and an operator from the +/- buttons.
//  - Computes A+B or A-B, converts the magnitude to 3-digit BCD with a fixed 8-cycle double-dabble.
//  - Supplies the value currently to be shown to the 7-segment display path.
//  - Sits between the debounced button/keypad pulse generators and the display mux.
// PARAMETERS
//  SHOW_TIMEOUT  0  cycles spent in SHOW before auto-return to IDLE; 0 = never
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   reset, asynchronous, active-low
//  btn_plus   in   1   one-cycle pulse, '+' button (debounced)
//  btn_minus  in   1   one-cycle pulse, '-' button (debounced)
//  key_valid  in   1   one-cycle pulse, key_val holds a digit
//  key_val    in   4   keypad digit; values >9 are ignored
//  state      out  3   0 IDLE, 1 ENTER_A, 2 ENTER_B, 3 CALC, 4 SHOW
//  op_a       out  8   operand A, 2 BCD digits {tens,ones}
//  op_b       out  8   operand B, 2 BCD digits
//  op_sub     out  1   latched operator: 0 add, 1 subtract
//  result     out  12  |A op B| as 3 BCD digits
//  neg        out  1   result negative (subtract with B>A)
//  busy       out  1   high while state==CALC
//  done       out  1   one-cycle pulse, result valid
//  disp_bcd   out  12  value to display: IDLE 0, ENTER_A {0,op_a}, ENTER_B {0,op_b}, CALC/SHOW result
//  disp_neg   out  1   minus sign for display: neg in SHOW, else 0
// BEHAVIOUR
//  - Reset: all outputs 0, state=IDLE, timeout counter 0. Takes effect mid-CALC too: no done pulse.
//  - Digit entry: valid key (key_valid & key_val<=9) shifts in: X <= {X[3:0],key_val}. Older MSD is dropped.
//  - Priority when pulses coincide: btn_plus > btn_minus > key_valid.
//  - Buttons: a pulse is a press.
//  - IDLE:
//     - valid key -> ENTER_A, op_a={4'h0,key}.
//     - buttons ignored.
//  - ENTER_A:
//     - valid key shifts into op_a.
//     - btn_plus -> op_sub=0; btn_minus -> op_sub=1. Either: op_b cleared, -> ENTER_B.
//  - ENTER_B:
//     - valid key shifts into op_b.
//     - any button acts as '=' and keeps the latched op_sub. -> CALC.
//     - On that edge:
//        - magnitude loaded: binary A=10*tens+ones, same for B;
//          add: A+B; sub: |A-B|; 8-bit, max 198.
//        - neg <= op_sub & (B>A).
//        - iteration count cleared.
//  - CALC:
//     - all inputs ignored.
//     - Each cycle does one double-dabble step: add 3 to any BCD nibble >=5, then shift left one bit.
//     - Exactly 8 cycles.
//     - On the 8th edge: result registered, state -> SHOW, done=1 for the first SHOW cycle only.
//     - busy=1 for exactly 8 cycles.
//  - SHOW:
//     - result, neg held.
//     - valid key -> ENTER_A with op_a={0,key}, op_b=0, neg=0.
//     - any button -> IDLE with op_a, op_b, result, neg, op_sub all cleared.
//     - SHOW_TIMEOUT>0: after SHOW_TIMEOUT consecutive cycles with no accepted input -> IDLE, cleared as above.
//     - The timeout counter resets on SHOW entry.
//  - Illegal state encodings 5..7 -> IDLE on the next edge.
//  - result is updated only on CALC exit; no X or partial values leave the block.
// TESTING
//  - Reset: hold rst_n=0, pulse all inputs -> state=0; op_a/op_b/result/neg/busy/done=0.
//  - Add: keys 4,7, btn_plus, keys 2,5, btn_plus -> busy for 8 cycles, then done pulse; result=12'h072, neg=0.
//  - Subtract: keys 1,2, btn_minus, keys 4,5, btn_minus -> result=12'h033, neg=1, disp_neg=1.
//  - Edge cases:
//     - 99+99 -> result=12'h198.
//     - keys 1,2,3 -> op_a=8'h23.
//     - key_val=4'hA ignored.
//     - btn_plus & btn_minus in same cycle -> op_sub=0.
//     - Key and button in same cycle in ENTER_A -> button wins, op_a unchanged.
//  - Mid-operation: assert rst_n=0 on 4th CALC cycle -> IDLE immediately, busy=0, no done.
//     Also: inputs pulsed during CALC -> no effect on operands.
//  - SHOW exits:
//     - SHOW_TIMEOUT=16, no input -> IDLE on 16th SHOW cycle.
//     - Key 7 in SHOW -> ENTER_A, op_a=8'h07.
//     - btn_minus in SHOW -> IDLE, all cleared.

Source files
------------

// File: rtl/cal_seq_ctrl.sv
// Sequencer for the two-operand pushbutton calculator: collects two 2-digit
// BCD operands and an operator, computes |A op B|, converts it to 3-digit BCD
// with a fixed 8-step double-dabble, and selects the value for the display.
module cal_seq_ctrl #(
  parameter int SHOW_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_plus,
  input  logic        btn_minus,
  input  logic        key_valid,
  input  logic [3:0]  key_val,
  output logic [2:0]  state,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  output logic        op_sub,
  output logic [11:0] result,
  output logic        neg,
  output logic        busy,
  output logic        done,
  output logic [11:0] disp_bcd,
  output logic        disp_neg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTER_A = 3'd1,
    S_ENTER_B = 3'd2,
    S_CALC    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  // Timeout counter counts 0..SHOW_TIMEOUT-1 while in SHOW.
  localparam int TW = (SHOW_TIMEOUT > 1) ? $clog2(SHOW_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((SHOW_TIMEOUT > 0) ? SHOW_TIMEOUT - 1 : 0);

  state_t state_reg, state_next;

  logic [7:0]    op_a_reg, op_b_reg;
  logic          op_sub_reg, neg_reg, done_reg;
  logic [11:0]   result_reg;
  logic [7:0]    dd_bin_reg;
  logic [11:0]   dd_bcd_reg;
  logic [2:0]    iter_reg;
  logic [TW-1:0] tmo_reg;

  // Control strobes from the FSM to the datapath
  logic a_load, a_shift, b_clear, b_shift, op_latch;
  logic calc_start, calc_step, calc_last, neg_clr, clr_all;

  logic key_ok, any_btn;
  logic [7:0]  bin_a, bin_b, mag;
  logic [11:0] bcd_adj, step_bcd;
  logic [7:0]  step_bin;

  assign key_ok  = key_valid && (key_val <= 4'd9);
  assign any_btn = btn_plus | btn_minus;

  // Operands are decimal-digit pairs; digits are always <= 9 so 8 bits suffice.
  assign bin_a = {4'h0, op_a_reg[7:4]} * 8'd10 + {4'h0, op_a_reg[3:0]};
  assign bin_b = {4'h0, op_b_reg[7:4]} * 8'd10 + {4'h0, op_b_reg[3:0]};
  assign mag   = !op_sub_reg ? (bin_a + bin_b)
               : (bin_b > bin_a) ? (bin_b - bin_a) : (bin_a - bin_b);

  // One double-dabble step: correct each nibble >= 5, then shift {bcd,bin} left.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (dd_bcd_reg[gi*4 +: 4] >= 4'd5)
                                ? dd_bcd_reg[gi*4 +: 4] + 4'd3
                                : dd_bcd_reg[gi*4 +: 4];
    end
  endgenerate
  assign step_bcd = {bcd_adj[10:0], dd_bin_reg[7]};
  assign step_bin = {dd_bin_reg[6:0], 1'b0};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and control strobes; buttons take priority over keys
  always_comb begin
    state_next = state_reg;
    a_load     = 1'b0;
    a_shift    = 1'b0;
    b_clear    = 1'b0;
    b_shift    = 1'b0;
    op_latch   = 1'b0;
    calc_start = 1'b0;
    calc_step  = 1'b0;
    calc_last  = 1'b0;
    neg_clr    = 1'b0;
    clr_all    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (key_ok) begin
          a_load     = 1'b1;
          b_clear    = 1'b1;
          state_next = S_ENTER_A;
        end
      end
      S_ENTER_A: begin
        if (any_btn) begin
          op_latch   = 1'b1;
          b_clear    = 1'b1;
          state_next = S_ENTER_B;
        end else if (key_ok) begin
          a_shift = 1'b1;
        end
      end
      S_ENTER_B: begin
        if (any_btn) begin
          calc_start = 1'b1;
          state_next = S_CALC;
        end else if (key_ok) begin
          b_shift = 1'b1;
        end
      end
      S_CALC: begin
        calc_step = 1'b1;
        if (iter_reg == 3'd7) begin
          calc_last  = 1'b1;
          state_next = S_SHOW;
        end
      end
      S_SHOW: begin
        if (any_btn) begin
          clr_all    = 1'b1;
          state_next = S_IDLE;
        end else if (key_ok) begin
          a_load     = 1'b1;
          b_clear    = 1'b1;
          neg_clr    = 1'b1;
          state_next = S_ENTER_A;
        end else if ((SHOW_TIMEOUT > 0) && (tmo_reg == TMO_LAST)) begin
          clr_all    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers driven by the control strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      op_sub_reg <= 1'b0;
      result_reg <= '0;
      neg_reg    <= 1'b0;
      done_reg   <= 1'b0;
      dd_bin_reg <= '0;
      dd_bcd_reg <= '0;
      iter_reg   <= '0;
      tmo_reg    <= '0;
    end else begin
      done_reg <= calc_last;
      if (a_load)       op_a_reg <= {4'h0, key_val};
      else if (a_shift) op_a_reg <= {op_a_reg[3:0], key_val};
      if (b_clear)      op_b_reg <= '0;
      else if (b_shift) op_b_reg <= {op_b_reg[3:0], key_val};
      // With both buttons pressed, '+' wins
      if (op_latch) op_sub_reg <= ~btn_plus;
      if (calc_start) begin
        dd_bin_reg <= mag;
        dd_bcd_reg <= '0;
        iter_reg   <= '0;
        neg_reg    <= op_sub_reg & (bin_b > bin_a);
      end
      if (calc_step) begin
        dd_bin_reg <= step_bin;
        dd_bcd_reg <= step_bcd;
        iter_reg   <= iter_reg + 3'd1;
      end
      // result only ever takes a fully converted value
      if (calc_last) result_reg <= step_bcd;
      if (neg_clr)   neg_reg    <= 1'b0;
      if (clr_all) begin
        op_a_reg   <= '0;
        op_b_reg   <= '0;
        op_sub_reg <= 1'b0;
        result_reg <= '0;
        neg_reg    <= 1'b0;
      end
      // Held at zero outside SHOW so it restarts on every SHOW entry
      if (state_reg == S_SHOW) tmo_reg <= tmo_reg + 1'b1;
      else                     tmo_reg <= '0;
    end
  end

  // Output mapping and display selection
  always_comb begin
    disp_bcd = 12'h000;
    case (state_reg)
      S_ENTER_A:      disp_bcd = {4'h0, op_a_reg};
      S_ENTER_B:      disp_bcd = {4'h0, op_b_reg};
      S_CALC, S_SHOW: disp_bcd = result_reg;
      default:        disp_bcd = 12'h000;
    endcase
  end

  assign state    = state_reg;
  assign op_a     = op_a_reg;
  assign op_b     = op_b_reg;
  assign op_sub   = op_sub_reg;
  assign result   = result_reg;
  assign neg      = neg_reg;
  assign busy     = (state_reg == S_CALC);
  assign done     = done_reg;
  assign disp_neg = (state_reg == S_SHOW) & neg_reg;

endmodule
